rr_grant_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4-way resource (bus, port or datapath slot) between four requesters.
- Issues a registered one-hot grant and the matching binary grant index; the index is the select input for the shared datapath.
- Enforces fairness with a rotating priority pointer and a maximum-hold timeout.
- Sits between requester blocks and the shared resource's select/enable logic.

---
 rtl/arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 26 ++
 rtl/rr_grant_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_grant_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the round-robin grant arbiter.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of mask at or after ptr, wrapping modulo N_REQ.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] k;

    always_comb begin
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = ptr + IDX_W'(i);
            if (!any && mask[k]) begin
                idx = k;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Four-way round-robin arbiter with registered one-hot grant and max-hold pre-emption.
//
// state | meaning
// IDLE  | no owner; first request seen is granted from ptr onwards
// GRANT | owner holds the resource; hand-over on release or hold timeout
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout_evt
);

    localparam int HC_W       = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
    localparam int HOLD_SAT_I = (MAX_HOLD == 0) ? ((1 << HC_W) - 1) : (MAX_HOLD - 1);
    localparam logic [HC_W-1:0] HOLD_SAT = HOLD_SAT_I[HC_W-1:0];

    state_t           state, state_nx;
    logic [IDX_W-1:0] owner, owner_nx;
    logic [IDX_W-1:0] ptr, ptr_nx;
    logic [N_REQ-1:0] grant_nx;
    logic [HC_W-1:0]  hold_cnt, hold_nx;
    logic             tmo_nx;

    logic [N_REQ-1:0] others;
    logic [IDX_W-1:0] owner_inc;
    logic [N_REQ-1:0] pick_mask;
    logic [IDX_W-1:0] pick_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    assign others    = req & ~idx_to_onehot(owner);
    assign owner_inc = owner + IDX_W'(1);

    // One picker serves both the initial grant and the hand-over.
    assign pick_mask = (state == IDLE) ? req : others;
    assign pick_ptr  = (state == IDLE) ? ptr : owner_inc;

    rr_pick u_pick (
        .mask (pick_mask),
        .ptr  (pick_ptr),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= '0;
            ptr         <= '0;
            grant       <= '0;
            hold_cnt    <= '0;
            timeout_evt <= 1'b0;
        end else begin
            state       <= state_nx;
            owner       <= owner_nx;
            ptr         <= ptr_nx;
            grant       <= grant_nx;
            hold_cnt    <= hold_nx;
            timeout_evt <= tmo_nx;
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        ptr_nx   = ptr;
        grant_nx = grant;
        hold_nx  = hold_cnt;
        tmo_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx = GRANT;
                    owner_nx = pick_idx;
                    grant_nx = idx_to_onehot(pick_idx);
                    hold_nx  = '0;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    // Release wins over a coincident timeout.
                    ptr_nx  = owner_inc;
                    hold_nx = '0;
                    if (pick_any) begin
                        owner_nx = pick_idx;
                        grant_nx = idx_to_onehot(pick_idx);
                    end else begin
                        state_nx = IDLE;
                        owner_nx = '0;
                        grant_nx = '0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_SAT) && pick_any) begin
                    ptr_nx   = owner_inc;
                    owner_nx = pick_idx;
                    grant_nx = idx_to_onehot(pick_idx);
                    hold_nx  = '0;
                    tmo_nx   = 1'b1;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_nx = hold_cnt + HC_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                owner_nx = '0;
                grant_nx = '0;
                hold_nx  = '0;
            end
        endcase
    end

    assign grant_idx   = owner;
    assign grant_valid = |grant;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: directed scenarios plus a random soak with resets.
module tb_rr_grant_arbiter;

    localparam int MH    = 4;
    localparam int BOUND = 3 * MH + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout_evt;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] idx;
        logic       v;
        logic       t;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   tmo_seen = 0;
    int   wait_cnt[4];

    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    rr_grant_arbiter #(.MAX_HOLD(MH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    function automatic int pick(input logic [3:0] m, input int p);
        for (int i = 0; i < 4; i++) begin
            if (m[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    task automatic push_expect(input bit tmo);
        exp_t e;
        e.g   = (m_owner < 0) ? 4'b0 : (4'b1 << m_owner);
        e.idx = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        e.v   = (m_owner >= 0);
        e.t   = tmo;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
    endtask

    // Owner is an int (-1 = none); the hold count is an unbounded cycle count.
    task automatic model_step(input logic [3:0] r);
        logic [3:0] oth;
        bit tmo;
        tmo = 0;
        if (m_owner < 0) begin
            if (r != 4'b0) begin
                m_owner = pick(r, m_ptr);
                m_hold  = 0;
            end
        end else begin
            oth = r & ~(4'b1 << m_owner);
            if (!r[m_owner]) begin
                m_ptr = (m_owner + 1) % 4;
                m_owner = (oth != 4'b0) ? pick(oth, m_ptr) : -1;
                m_hold = 0;
            end else if (m_hold >= MH - 1 && oth != 4'b0) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = pick(oth, m_ptr);
                m_hold  = 0;
                tmo     = 1;
            end else begin
                m_hold++;
            end
        end
        push_expect(tmo);
    endtask

    task automatic step(input logic [3:0] r);
        @(negedge clk);
        req = r;
        model_step(r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_idx", 32'(grant_idx), 32'h0);
        check("rst_valid", 32'(grant_valid), 32'h0);
        check("rst_tmo", 32'(timeout_evt), 32'h0);
        req = 4'b0;
        model_reset();
        push_expect(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_step(4'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant", 32'(grant), 32'(e.g));
                check("grant_idx", 32'(grant_idx), 32'(e.idx));
                check("grant_valid", 32'(grant_valid), 32'(e.v));
                check("timeout_evt", 32'(timeout_evt), 32'(e.t));
            end
            check("onehot", 32'($countones(grant) <= 1), 32'h1);
            if (grant_valid) check("grant_vs_idx", 32'(grant), 32'(4'b1 << grant_idx));
            if (timeout_evt === 1'b1) tmo_seen++;
            for (int i = 0; i < 4; i++) begin
                if (!rst_n || !req[i] || grant[i]) wait_cnt[i] = 0;
                else wait_cnt[i]++;
                if (wait_cnt[i] > 0) check("starvation", 32'(wait_cnt[i] <= BOUND), 32'h1);
            end
        end
    end

    initial begin : stimulus
        logic [3:0] r;
        int t0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;

        #3;
        check("init_grant", 32'(grant), 32'h0);
        check("init_valid", 32'(grant_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        model_step(4'b0);

        // reset mid-grant, then first grant
        step(4'b0001);
        step(4'b0001);
        do_reset();
        step(4'b0100);
        step(4'b0100);
        step(4'b0000);

        // rotation with ptr=0
        do_reset();
        step(4'b1111);
        step(4'b1110);
        step(4'b1101);
        step(4'b1011);
        step(4'b0111);
        step(4'b0000);

        // release to idle, then ptr=2 favours requester 3
        do_reset();
        step(4'b0010);
        step(4'b0010);
        step(4'b0000);
        step(4'b0000);
        step(4'b1001);
        step(4'b0000);

        // timeout: requester 0 holds, requester 2 arrives at cycle 2
        do_reset();
        t0 = tmo_seen;
        for (int k = 0; k < 10; k++) begin
            r = 4'b0001;
            if (k >= 2 && k <= 5) r[2] = 1'b1;
            step(r);
        end
        step(4'b0000);
        step(4'b0000);
        @(negedge clk);
        check("tmo_once", 32'(tmo_seen - t0), 32'h1);

        // no contention: no pre-emption
        do_reset();
        t0 = tmo_seen;
        for (int k = 0; k < 20; k++) step(4'b1000);
        step(4'b0000);
        @(negedge clk);
        check("tmo_none", 32'(tmo_seen - t0), 32'h0);

        // random soak
        r = 4'b0;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
                r = 4'b0;
            end else begin
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
                step(r);
            end
        end
        step(4'b0000);
        step(4'b0000);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
